// File: rtl/inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction fetch sequencer. Owns the byte-addressed fetch PC, presents it
// to an instruction memory that answers combinationally, and captures each
// returned word together with its PC into a small circular prefetch queue.
// Decode drains the queue head with a valid/ready handshake. A redirect
// restarts fetch at a new target and flushes everything already prefetched;
// a misaligned redirect target parks the block in a FAULT state until an
// aligned redirect or reset.
//
// Ports:
//   clk            system clock, rising-edge active
//   rst            asynchronous active-high reset
//   fetch_en       1 = allow new fetches, 0 = pause (queue still drains)
//   mem_addr       byte address to instruction memory (always fetch_pc)
//   mem_data       instruction word returned for mem_addr
//   out_valid      queue head holds a valid instruction
//   out_ready      decode accepts the head this cycle
//   out_inst       head instruction word
//   out_pc         byte address of the head instruction
//   redirect_valid one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc    redirect target byte address
//   fault          misaligned redirect seen, fetch halted
//   fault_pc       offending redirect target
//   q_count        current queue occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter int                ADDR_W   = 15,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [31:0]                mem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       fault,
    output logic [ADDR_W-1:0]          fault_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   fault_pc_q;

    logic [31:0]         q_inst [DEPTH];
    logic [ADDR_W-1:0]   q_pc   [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;

    logic                pop;
    logic                push;
    logic                misaligned;

    // Handshake and fetch qualification. A full queue may still accept a
    // new word when the head leaves in the same cycle, so the queue keeps
    // streaming at one instruction per cycle without a bubble.
    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign push       = (state == ST_RUN) & fetch_en & ~redirect_valid &
                        ((count < DEPTH_CNT) | pop);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: only a redirect moves the machine, in either
    // direction, and its alignment picks the destination.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = misaligned ? ST_FAULT : ST_RUN;
        end
    end

    // Fetch PC. A redirect always loads the target, even a misaligned one,
    // so mem_addr shows the offending address while faulted. Increment
    // wraps naturally at the top of the address space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // Captured fault address; kept after recovery so software can still
    // inspect the last offending target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_pc_q <= '0;
        end else if (redirect_valid && misaligned) begin
            fault_pc_q <= redirect_pc;
        end
    end

    // Queue pointers and occupancy. A redirect discards everything; any
    // pop in that cycle is implicitly completed because the head is gone
    // either way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: nothing is read from a slot until a
    // push has written it, and the outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= mem_data;
            q_pc[wr_ptr]   <= fetch_pc;
        end
    end

    // Outputs read zero whenever the queue is empty, which also makes them
    // clear immediately on an asynchronous reset.
    assign mem_addr = fetch_pc;
    assign out_inst = out_valid ? q_inst[rd_ptr] : '0;
    assign out_pc   = out_valid ? q_pc[rd_ptr]   : '0;
    assign fault    = (state == ST_FAULT);
    assign fault_pc = fault_pc_q;
    assign q_count  = count;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//
// Directed bench for inst_fetch_ctrl. The instruction memory is a pure
// function of the address, so the expected word for any PC can be formed
// locally. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              fetch_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              fault;
    logic [ADDR_W-1:0] fault_pc;
    logic [2:0]        q_count;

    int vecCount  = 0;
    int missCount = 0;

    inst_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .q_count        (q_count)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word derived from its own address.
    function automatic logic [31:0] wordAt(input logic [ADDR_W-1:0] pc);
        return {pc[7:0], 8'hA5, 1'b0, pc};
    endfunction

    assign mem_data = wordAt(mem_addr);

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkHead(input string tag, input logic [ADDR_W-1:0] pc);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_pc"},    32'(out_pc),    32'(pc));
        checkOutput({tag, "_inst"},  out_inst,       wordAt(pc));
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_count", 32'(q_count),   32'd0);
        checkOutput("rst_inst",  out_inst,       32'd0);
        checkOutput("rst_pc",    32'(out_pc),    32'd0);
        checkOutput("rst_fault", 32'(fault),     32'd0);
        checkOutput("rst_fpc",   32'(fault_pc),  32'd0);
        checkOutput("rst_maddr", 32'(mem_addr),  32'd0);
        rst = 1'b0;
        checkOutput("rel_valid", 32'(out_valid), 32'd0);

        // Streaming: one instruction per cycle, occupancy steady at 1.
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkHead("stream", ADDR_W'(4 * i));
            checkOutput("stream_count", 32'(q_count), 32'd1);
        end

        // Backpressure: queue fills to DEPTH, fetch PC freezes at 16.
        out_ready = 1'b0;
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("bp_count", 32'(q_count),  32'd4);
        checkOutput("bp_maddr", 32'(mem_addr), 32'd16);
        checkHead("bp_hold", 15'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkHead("drain", ADDR_W'(4 * i));
            checkOutput("drain_count", 32'(q_count), 32'd4);
            applyStimulus();
        end

        // Bring the queue down to three entries (head 36, fetch_pc 48).
        fetch_en = 1'b0;
        applyStimulus();
        checkOutput("pre_rd_count", 32'(q_count), 32'd3);
        checkHead("pre_rd", 15'd36);

        // Aligned redirect with a pop in the same cycle.
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 15'h0100;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("rd_valid", 32'(out_valid), 32'd0);
        checkOutput("rd_count", 32'(q_count),   32'd0);
        checkOutput("rd_maddr", 32'(mem_addr),  32'h0100);
        applyStimulus();
        checkHead("rd_tgt", 15'h0100);

        // Misaligned redirect: fault, no fetching while fault is held.
        redirect_valid = 1'b1;
        redirect_pc    = 15'h0102;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("flt_fault", 32'(fault),    32'd1);
        checkOutput("flt_fpc",   32'(fault_pc), 32'h0102);
        checkOutput("flt_maddr", 32'(mem_addr), 32'h0102);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("flt_valid", 32'(out_valid), 32'd0);
            checkOutput("flt_count", 32'(q_count),   32'd0);
            checkOutput("flt_hold",  32'(fault),     32'd1);
        end

        // Recovery through an aligned redirect; fault_pc is retained.
        redirect_valid = 1'b1;
        redirect_pc    = 15'h0200;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("rec_fault", 32'(fault),     32'd0);
        checkOutput("rec_fpc",   32'(fault_pc),  32'h0102);
        checkOutput("rec_valid", 32'(out_valid), 32'd0);
        applyStimulus();
        checkHead("rec_tgt", 15'h0200);

        // Wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 15'h7FF8;
        applyStimulus();
        redirect_valid = 1'b0;
        applyStimulus();
        checkHead("wrap0", 15'h7FF8);
        applyStimulus();
        checkHead("wrap1", 15'h7FFC);
        applyStimulus();
        checkHead("wrap2", 15'h0000);
        applyStimulus();
        checkHead("wrap3", 15'h0004);

        // Pause: queue drains, fetch PC frozen, then resumes at 8.
        fetch_en = 1'b0;
        applyStimulus();
        checkOutput("pause_valid", 32'(out_valid), 32'd0);
        checkOutput("pause_count", 32'(q_count),   32'd0);
        applyStimulus();
        checkOutput("pause_maddr", 32'(mem_addr),  32'd8);
        fetch_en = 1'b1;
        applyStimulus();
        checkHead("resume", 15'd8);

        // Asynchronous reset in the middle of a cycle with a full queue.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("full_count", 32'(q_count), 32'd4);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_count", 32'(q_count),   32'd0);
        checkOutput("arst_pc",    32'(out_pc),    32'd0);
        checkOutput("arst_inst",  out_inst,       32'd0);
        checkOutput("arst_maddr", 32'(mem_addr),  32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        applyStimulus();
        checkHead("restart0", 15'd0);
        applyStimulus();
        checkHead("restart1", 15'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
